// File: rtl/rs232_bus_bridge.sv
// rs232_bus_bridge
//   Bus initiator driven by a UART byte stream (debug / boot loading).
//   Host frames, MSB first:  'R' + ADDR_B address bytes
//                            'W' + ADDR_B address bytes + DATA_B data bytes
//   Each frame issues one read or write cycle on the CPU-side bus. The reply goes out
//   through the transmitter byte port: read data bytes, 'K' for a write, '?' for an
//   unknown command byte.
//   Optional macro BRIDGE_TIMEOUT_EN: abort a bus cycle after TIMEOUT_CYCLES waiting
//   cycles and reply 'T'.
module rs232_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              read_q,
  output logic              write_q,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_dn,
  input  logic              write_dn,
  input  logic              rw_halt_in,
  output logic              overrun
);

  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;

  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] RPL_OK    = 8'h4B;
  localparam logic [7:0] RPL_UNK   = 8'h3F;
  localparam logic [7:0] RPL_TMOUT = 8'h54;

  // Byte counters are 8 bits wide, so frames are limited to 255 bytes per field.
  if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 2040) begin : g_bad_addr_w
    $error("ADDR_W must be a multiple of 8 between 8 and 2040");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 2040) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8 between 8 and 2040");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_BUS   = 3'd3,
    ST_REPLY = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [DATA_W-1:0] reply_q, reply_d;
  logic [7:0]        reply_cnt_q, reply_cnt_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              guard_q, guard_d;
  logic              overrun_q, overrun_d;

  logic is_cmd_s, dn_ok_s, timeout_s, issue_s, last_addr_s, last_data_s;

  // Place a single reply byte in the top lane of the reply shift register.
  function automatic logic [DATA_W-1:0] top_byte(input logic [7:0] b);
    return DATA_W'(b) << (DATA_W - 8);
  endfunction

  // Decode helpers shared by the next-state and datapath logic.
  always_comb begin
    is_cmd_s    = (rx_byte == CMD_RD) || (rx_byte == CMD_WR);
    // Only the done of the requested type counts, and never while the responder stalls.
    dn_ok_s     = !rw_halt_in && (cmd_wr_q ? write_dn : read_dn);
    // A reply byte goes out only after the previous strobe and its guard cycle.
    issue_s     = (state_q == ST_REPLY) && !tx_busy && !tx_start_q && !guard_q;
    last_addr_s = (byte_cnt_q == 8'(ADDR_B - 1));
    last_data_s = (byte_cnt_q == 8'(DATA_B - 1));
  end

`ifdef BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  // Bus-wait counter: held at zero outside BUS so every bus cycle starts from zero.
  always_comb begin
    if (state_q == ST_BUS) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end else begin
      to_cnt_d = 32'd0;
    end
    timeout_s = (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  // Bus-wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Without the timeout option the bus cycle waits for done indefinitely.
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame parsing, bus wait and reply sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          state_d = is_cmd_s ? ST_ADDR : ST_REPLY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_valid && last_addr_s) begin
          state_d = cmd_wr_q ? ST_WDATA : ST_BUS;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (rx_valid && last_data_s) begin
          state_d = ST_BUS;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_BUS: begin
        if (dn_ok_s || timeout_s) begin
          state_d = ST_REPLY;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_REPLY: begin
        if (issue_s && (reply_cnt_q == 8'd1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values for each state.
  always_comb begin
    cmd_wr_d    = cmd_wr_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    reply_d     = reply_q;
    reply_cnt_d = reply_cnt_q;
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    guard_d     = tx_start_q;
    // Bytes arriving while a bus cycle or reply is in progress are dropped.
    overrun_d   = overrun_q | (rx_valid && ((state_q == ST_BUS) || (state_q == ST_REPLY)));
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && is_cmd_s) begin
          cmd_wr_d   = (rx_byte == CMD_WR);
          byte_cnt_d = 8'd0;
        end else if (rx_valid) begin
          reply_d     = top_byte(RPL_UNK);
          reply_cnt_d = 8'd1;
        end else begin
          byte_cnt_d = 8'd0;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d = (addr_q << 8) | ADDR_W'(rx_byte);
          if (last_addr_s) begin
            byte_cnt_d = 8'd0;
            rd_req_d   = !cmd_wr_q;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      ST_WDATA: begin
        if (rx_valid) begin
          wdata_d = (wdata_q << 8) | DATA_W'(rx_byte);
          if (last_data_s) begin
            byte_cnt_d = 8'd0;
            wr_req_d   = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      ST_BUS: begin
        if (dn_ok_s) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          if (cmd_wr_q) begin
            reply_d     = top_byte(RPL_OK);
            reply_cnt_d = 8'd1;
          end else begin
            reply_d     = data_in;
            reply_cnt_d = 8'(DATA_B);
          end
        end else if (timeout_s) begin
          rd_req_d    = 1'b0;
          wr_req_d    = 1'b0;
          reply_d     = top_byte(RPL_TMOUT);
          reply_cnt_d = 8'd1;
        end else begin
          rd_req_d = rd_req_q;
          wr_req_d = wr_req_q;
        end
      end
      ST_REPLY: begin
        if (issue_s) begin
          tx_start_d  = 1'b1;
          tx_byte_d   = reply_q[DATA_W-1 -: 8];
          reply_d     = reply_q << 8;
          reply_cnt_d = reply_cnt_q - 8'd1;
        end else begin
          tx_start_d = 1'b0;
        end
      end
      default: begin
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset discards any partial frame or reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_q    <= 1'b0;
      byte_cnt_q  <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      reply_q     <= '0;
      reply_cnt_q <= 8'd0;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= 8'd0;
      guard_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cmd_wr_q    <= cmd_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      reply_q     <= reply_d;
      reply_cnt_q <= reply_cnt_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
      guard_q     <= guard_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign addr_out = addr_q;
  assign data_out = wdata_q;
  assign read_q   = rd_req_q;
  assign write_q  = wr_req_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_rs232_bus_bridge.sv
// Self-checking bench for rs232_bus_bridge: directed frame table, hand-written reset /
// overrun / timeout sequences and randomized frames checked against a frame-level model.
module tb_rs232_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic [31:0] addr_out, data_out, data_in;
  logic        read_q, write_q, read_dn, write_dn, rw_halt_in, overrun;

  rs232_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .addr_out(addr_out), .data_out(data_out),
    .read_q(read_q), .write_q(write_q), .data_in(data_in), .read_dn(read_dn),
    .write_dn(write_dn), .rw_halt_in(rw_halt_in), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          delay;     // done asserted from request cycle delay+1
    int          halt;      // stall held for the first halt request cycles
    logic        wrong;     // wrong-type done during the wait
    int          tx_lat;    // transmitter busy cycles per byte
    logic        inject;    // extra byte sent while the bus cycle is pending
    logic        chk_lat;   // check done-to-first-strobe latency
    int          exp_n;
    logic [31:0] exp_bytes; // expected reply bytes, MSB first
    int          exp_ops;
    int          exp_len;   // expected request length in cycles
  } vec_t;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
    logic        stable;
  } bus_rec_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int dn_cyc = 0;
  int start_while_busy = 0;
  int byte_unstable = 0;
  int resp_delay = 0, resp_halt = 0, tx_lat = 0;
  logic resp_wrong = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  logic [7:0] txq[$];
  int txc[$];
  bus_rec_t bus_log[$];
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: what a frame should do on the bus and send back.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.cmd == 8'h52) begin
      r.exp_ops = 1; r.exp_n = 4; r.exp_bytes = v.rdata;
      r.exp_len = ((v.delay > v.halt) ? v.delay : v.halt) + 1;
    end else if (v.cmd == 8'h57) begin
      r.exp_ops = 1; r.exp_n = 1; r.exp_bytes = 32'h4B000000;
      r.exp_len = ((v.delay > v.halt) ? v.delay : v.halt) + 1;
    end else begin
      r.exp_ops = 0; r.exp_n = 1; r.exp_bytes = 32'h3F000000; r.exp_len = 0;
    end
    r.chk_lat = (r.exp_ops == 1);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int sel = $urandom_range(0, 4);
    logic [7:0] other = 8'($urandom);
    if (other == 8'h52 || other == 8'h57) other = 8'h00;
    v.cmd    = (sel < 2) ? 8'h52 : (sel < 4) ? 8'h57 : other;
    v.addr   = $urandom;
    v.data   = $urandom;
    v.rdata  = $urandom;
    v.delay  = $urandom_range(0, 5);
    v.halt   = $urandom_range(0, 6);
    v.wrong  = 1'($urandom_range(0, 1));
    v.tx_lat = $urandom_range(0, 4);
    v.inject = 1'b0;
    return model(v);
  endfunction

  // Cycle counter, read on falling edges.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: logs strobes, goes busy for tx_lat cycles, checks handshake rules.
  initial begin : transmitter
    int left = 0;
    logic [7:0] held = 8'h00;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_busy && tx_byte !== held) byte_unstable++;
      if (tx_start) begin
        if (tx_busy) start_while_busy++;
        txq.push_back(tx_byte);
        txc.push_back(cyc);
        held = tx_byte;
        left = tx_lat;
      end
      if (left > 0) begin
        tx_busy = 1'b1;
        left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Bus responder: stalls, answers after a delay, logs each completed request.
  initial begin : responder
    int k = 0;
    logic dn, wr;
    bus_rec_t cur;
    read_dn = 1'b0; write_dn = 1'b0; rw_halt_in = 1'b0; data_in = 32'h0;
    forever begin
      @(negedge clk);
      if (read_q || write_q) begin
        k++;
        if (k == 1) begin
          cur.is_wr = write_q; cur.addr = addr_out; cur.data = data_out; cur.stable = 1'b1;
        end else if (addr_out !== cur.addr || data_out !== cur.data || write_q !== cur.is_wr) begin
          cur.stable = 1'b0;
        end
        rw_halt_in = (k <= resp_halt);
        dn = (k > resp_delay);
        wr = resp_wrong && !dn;
        read_dn  = read_q ? dn : wr;
        write_dn = write_q ? dn : wr;
        data_in  = (read_q && dn && !rw_halt_in) ? resp_rdata : $urandom;
        if (dn && !rw_halt_in) dn_cyc = cyc;
      end else begin
        if (k > 0) begin
          cur.len = k;
          bus_log.push_back(cur);
        end
        k = 0; read_dn = 1'b0; write_dn = 1'b0; rw_halt_in = 1'b0; data_in = $urandom;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(v.cmd);
    if (v.cmd == 8'h52 || v.cmd == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(v.addr[8*i +: 8]);
    if (v.cmd == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(v.data[8*i +: 8]);
  endtask

  task automatic run_vector(input vec_t v);
    resp_delay = v.delay; resp_halt = v.halt; resp_wrong = v.wrong;
    resp_rdata = v.rdata; tx_lat = v.tx_lat;
    txq.delete(); txc.delete(); bus_log.delete();
    send_frame(v);
    if (v.inject) begin
      repeat (2) @(negedge clk);
      send_byte(8'h55);
    end
    for (int c = 0; c < 600 && txq.size() < v.exp_n; c++) @(negedge clk);
    repeat (12) @(negedge clk);
    check("tx_count", txq.size(), v.exp_n);
    for (int i = 0; i < v.exp_n && i < txq.size(); i++)
      check($sformatf("tx_byte%0d", i), txq[i], v.exp_bytes[31-8*i -: 8]);
    check("bus_ops", bus_log.size(), v.exp_ops);
    if (v.exp_ops == 1 && bus_log.size() == 1) begin
      check("bus_is_write", bus_log[0].is_wr, v.cmd == 8'h57);
      check("bus_addr", bus_log[0].addr, v.addr);
      if (v.cmd == 8'h57) check("bus_wdata", bus_log[0].data, v.data);
      check("bus_len", bus_log[0].len, v.exp_len);
      check("bus_stable", bus_log[0].stable, 1);
      if (v.chk_lat && txc.size() > 0) check("reply_latency", txc[0] - dn_cyc, 2);
    end
  endtask

  initial begin
    vec_t v;
    //        cmd    addr          data          rdata         dly hlt wrg lat inj lat? n  bytes         ops len
    tbl[0] = '{8'h57, 32'h00000100, 32'hDEADBEEF, 32'h00000000, 2, 0, 1'b0, 2, 1'b0, 1'b1, 1, 32'h4B000000, 1, 3};
    tbl[1] = '{8'h52, 32'h00000020, 32'h00000000, 32'h12345678, 1, 0, 1'b0, 3, 1'b0, 1'b1, 4, 32'h12345678, 1, 2};
    tbl[2] = '{8'h41, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1, 32'h3F000000, 0, 0};
    tbl[3] = '{8'h52, 32'h80000004, 32'h00000000, 32'hCAFEF00D, 0, 5, 1'b0, 0, 1'b0, 1'b1, 4, 32'hCAFEF00D, 1, 6};
    tbl[4] = '{8'h57, 32'hFFFFFFFC, 32'h0BADF00D, 32'h00000000, 3, 0, 1'b1, 4, 1'b0, 1'b1, 1, 32'h4B000000, 1, 4};
    tbl[5] = '{8'h52, 32'h00000000, 32'h00000000, 32'hA5000001, 0, 0, 1'b0, 0, 1'b0, 1'b1, 4, 32'hA5000001, 1, 1};

    repeat (3) @(negedge clk);
    check("rst_tx", {tx_start, tx_byte}, 0);
    check("rst_req", {read_q, write_q}, 0);
    check("rst_addr", addr_out, 0);
    check("rst_data", data_out, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vector(tbl[i]);
    check("overrun_idle", overrun, 0);

    // A byte arriving during a pending bus cycle is dropped and flagged.
    v = tbl[1];
    v.delay = 9; v.exp_len = 10; v.inject = 1'b1; v.rdata = 32'h55AA33CC; v.exp_bytes = 32'h55AA33CC;
    run_vector(v);
    check("overrun_set", overrun, 1);

    for (int i = 0; i < 10; i++) run_vector(rand_vec());
    check("overrun_sticky", overrun, 1);

    // Reset during a pending read drops the request on the next edge and sends nothing.
    resp_delay = 1000; resp_halt = 0; resp_wrong = 1'b0;
    txq.delete(); bus_log.delete();
    send_frame(tbl[1]);
    repeat (3) @(negedge clk);
    check("rd_before_rst", read_q, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rd_after_rst", read_q, 0);
    check("overrun_cleared", overrun, 0);
    repeat (20) @(negedge clk);
    check("no_tx_after_rst", txq.size(), 0);
    check("rd_stays_low", read_q, 0);

    // A partial frame is discarded by reset; the next frame parses from scratch.
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_vector(tbl[1]);

`ifdef BRIDGE_TIMEOUT_EN
    // No done ever: the request is abandoned after 16 bus cycles and 'T' is sent.
    v = tbl[3];
    v.delay = 1000; v.halt = 3; v.chk_lat = 1'b0;
    v.exp_n = 1; v.exp_bytes = 32'h54000000; v.exp_ops = 1; v.exp_len = 16;
    run_vector(v);
`endif

    for (int i = 0; i < 10; i++) run_vector(rand_vec());

    check("tx_start_while_busy", start_while_busy, 0);
    check("tx_byte_stable", byte_unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
